// File: rtl/gpio_input_irq.sv
// Input-side GPIO conditioning: per-pin 2-flop synchronizer, stability-count debouncer,
// rise/fall edge detection on the debounced level and sticky write-1-to-clear interrupt status.
module gpio_input_irq #(
  parameter int length   = 4,
  parameter int DEBOUNCE = 3   // legal range 1..255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [length-1:0] gpio_pins_in,
  input  logic [length-1:0] rise_en,
  input  logic [length-1:0] fall_en,
  input  logic [length-1:0] irq_clear,
  output logic [length-1:0] gpio_read,
  output logic [length-1:0] irq_status,
  output logic              irq
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic [length-1:0]            sync1_q,  sync1_d;
  logic [length-1:0]            sync2_q,  sync2_d;
  logic [length-1:0]            stable_q, stable_d;
  logic [length-1:0][CNT_W-1:0] cnt_q,    cnt_d;
  logic [length-1:0]            status_q, status_d;
  logic [length-1:0]            rise_evt, fall_evt;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sync1_d  = gpio_pins_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;

    for (int i = 0; i < length; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    // Edges exist only on the accept cycle, so enables are sampled exactly then.
    rise_evt = stable_d & ~stable_q;
    fall_evt = stable_q & ~stable_d;

    // Set terms are OR-ed after the clear so a same-cycle set wins.
    status_d = (status_q & ~irq_clear) | (rise_evt & rise_en) | (fall_evt & fall_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      status_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
    end
  end

  assign gpio_read  = stable_q;
  assign irq_status = status_q;
  assign irq        = |status_q;

endmodule

// File: tb/tb_gpio_input_irq.sv
// Directed self-checking bench for gpio_input_irq at length=4, DEBOUNCE=3
// (pin change to gpio_read takes 5 rising edges).
module tb_gpio_input_irq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gpio_pins_in;
  logic [3:0] rise_en;
  logic [3:0] fall_en;
  logic [3:0] irq_clear;
  logic [3:0] gpio_read;
  logic [3:0] irq_status;
  logic       irq;

  int n_checks = 0;
  int n_fails  = 0;

  gpio_input_irq #(.length(4), .DEBOUNCE(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .gpio_pins_in (gpio_pins_in),
    .rise_en      (rise_en),
    .fall_en      (fall_en),
    .irq_clear    (irq_clear),
    .gpio_read    (gpio_read),
    .irq_status   (irq_status),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; leaves time 1 unit past the last edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] rd, input logic [3:0] st);
    check({tag, "_read"},   32'(gpio_read),  32'(rd));
    check({tag, "_status"}, 32'(irq_status), 32'(st));
    check({tag, "_irq"},    32'(irq),        32'(|st));
  endtask

  initial begin
    // Reset with all pins high
    rst          = 1'b1;
    gpio_pins_in = 4'b1111;
    rise_en      = 4'b0000;
    fall_en      = 4'b0000;
    irq_clear    = 4'b0000;
    tick(3);
    check_all("reset", 4'b0000, 4'b0000);
    rst = 1'b0;
    tick(4);
    check_all("post_rst_e4", 4'b0000, 4'b0000);
    tick(1);
    check_all("post_rst_e5", 4'b1111, 4'b0000);

    // Bring all pins low with no enables: no status
    gpio_pins_in = 4'b0000;
    tick(5);
    check_all("all_low", 4'b0000, 4'b0000);

    // Rising interrupt on pin0
    rise_en      = 4'b0001;
    gpio_pins_in = 4'b0001;
    tick(4);
    check_all("rise_e4", 4'b0000, 4'b0000);
    tick(1);
    check_all("rise_e5", 4'b0001, 4'b0001);
    irq_clear = 4'b0001;
    tick(1);
    irq_clear = 4'b0000;
    check_all("rise_clr", 4'b0001, 4'b0000);
    irq_clear = 4'b1111;
    tick(1);
    irq_clear = 4'b0000;
    check_all("clr_zero", 4'b0001, 4'b0000);

    // Glitch of 2 cycles on pin2: rejected
    rise_en      = 4'b0100;
    gpio_pins_in = 4'b0101;
    tick(2);
    gpio_pins_in = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      check("glitch2_read", 32'(gpio_read), 32'h1);
      check("glitch2_status", 32'(irq_status), 32'h0);
    end

    // 3-cycle pulse on pin2: accepted, then released
    gpio_pins_in = 4'b0101;
    tick(3);
    gpio_pins_in = 4'b0001;
    tick(1);
    check_all("pulse3_e4", 4'b0001, 4'b0000);
    tick(1);
    check_all("pulse3_e5", 4'b0101, 4'b0100);
    tick(3);
    check_all("pulse3_fall", 4'b0001, 4'b0100);
    irq_clear = 4'b0100;
    tick(1);
    irq_clear = 4'b0000;
    check_all("pulse3_clr", 4'b0001, 4'b0000);

    // Falling and mixed edges
    rise_en      = 4'b0000;
    gpio_pins_in = 4'b1010;
    tick(5);
    check_all("mixed_setup", 4'b1010, 4'b0000);
    fall_en      = 4'b1000;
    rise_en      = 4'b0001;
    gpio_pins_in = 4'b0011;
    tick(5);
    check_all("mixed", 4'b0011, 4'b1001);
    irq_clear = 4'b0001;
    tick(1);
    irq_clear = 4'b0000;
    check_all("mixed_clr0", 4'b0011, 4'b1000);
    irq_clear = 4'b1000;
    tick(1);
    irq_clear = 4'b0000;
    check_all("mixed_clr3", 4'b0011, 4'b0000);

    // Simultaneous set and clear on pin3
    fall_en      = 4'b0000;
    rise_en      = 4'b0000;
    gpio_pins_in = 4'b1011;
    tick(5);
    check_all("sim_setup", 4'b1011, 4'b0000);
    fall_en      = 4'b1000;
    irq_clear    = 4'b1000;
    gpio_pins_in = 4'b0011;
    tick(4);
    check_all("sim_e4", 4'b1011, 4'b0000);
    tick(1);
    check_all("sim_e5", 4'b0011, 4'b1000);
    tick(1);
    check_all("sim_e6", 4'b0011, 4'b0000);
    irq_clear = 4'b0000;
    fall_en   = 4'b0000;

    // Reset in the middle of a pin0 debounce
    gpio_pins_in = 4'b0010;
    tick(5);
    check_all("mid_setup", 4'b0010, 4'b0000);
    rise_en      = 4'b0001;
    gpio_pins_in = 4'b0011;
    tick(2);
    rst = 1'b1;
    #1;
    check_all("mid_rst", 4'b0000, 4'b0000);
    tick(1);
    rst = 1'b0;
    tick(4);
    check_all("mid_e4", 4'b0000, 4'b0000);
    tick(1);
    check_all("mid_e5", 4'b0011, 4'b0001);
    tick(4);
    check_all("mid_hold", 4'b0011, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
